inter_pkt_delay: RTL and testbench
==================================

INTER_PKT_DELAY -- requirements
Module: inter_pkt_delay

Interface
REQ-001 C_M_AXIS_DATA_WIDTH, 256, master stream data width.
REQ-002 C_S_AXIS_DATA_WIDTH, 256, slave stream data width; SHALL equal C_M_AXIS_DATA_WIDTH.
REQ-003 C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
REQ-004 C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; SHALL equal C_M_AXIS_TUSER_WIDTH.
REQ-005 C_S_AXI_DATA_WIDTH, 32, width of the delay register.
REQ-006 axi_aclk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-007 axi_reset  in  1  synchronous, active-high reset.
REQ-008 s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per parameters  packets from the rate limiter; s_axis_tready out 1.
REQ-009 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per parameters  packets to the output port; m_axis_tready in 1.
REQ-010 sw_rst  in  1  software reset, same effect as axi_reset.
REQ-011 ipd_en  in  1  enables gap insertion.
REQ-012 ipd_cycles  in  C_S_AXI_DATA_WIDTH  gap length in clock cycles.
REQ-013 pkt_count  out  32  packets forwarded (tlast handshakes), wraps at 2^32.

Function
REQ-014 Data path SHALL be combinational pass-through: m_axis_tdata/tstrb/tuser/tlast = s_axis equivalents; zero latency.
REQ-015 m_axis_tvalid = s_axis_tvalid AND (state != GAP); s_axis_tready = m_axis_tready AND (state != GAP).
REQ-016 FSM states: IDLE (between packets), PASS (mid-packet), GAP (holding off).
REQ-017 IDLE -> PASS on handshake with tlast=0; IDLE -> GAP on handshake with tlast=1 when gap is armed; otherwise stays IDLE.
REQ-018 PASS -> GAP on tlast handshake when gap armed; PASS -> IDLE on tlast handshake when not armed.
REQ-019 "Gap armed" = ipd_en=1 AND the delay value latched at tlast is non-zero.
REQ-020 On entering GAP, gap_cnt SHALL load the delay value; each GAP cycle decrements; GAP -> IDLE in the cycle gap_cnt==1.
REQ-021 With last beat accepted in cycle T, the next first beat SHALL NOT be accepted before cycle T+1+delay; exactly T+1+delay if offered.
REQ-022 Delay value SHALL be sampled only at the tlast handshake; ipd_cycles changes during GAP SHALL NOT alter the running gap.
REQ-023 ipd_en deasserted during GAP SHALL force GAP -> IDLE next cycle.
REQ-024 Upstream tvalid held during GAP SHALL NOT be dropped; the beat transfers after GAP ends.
REQ-025 pkt_count SHALL increment by 1 on every tlast handshake, regardless of ipd_en.
REQ-026 ipd_cycles = 2^32-1 SHALL be honoured without counter overflow (32-bit gap_cnt).

Reset
REQ-027 axi_reset or sw_rst SHALL set state=IDLE, gap_cnt=0, and pkt_count=0 in the following cycle.
REQ-028 Reset asserted mid-packet or mid-GAP SHALL abort; the next accepted beat is treated as a packet start.
REQ-029 During reset, s_axis_tready and m_axis_tvalid SHALL follow REQ-015 with state=IDLE; no combinational dependency on reset.

Configuration
REQ-030 Macro INTER_PKT_DELAY_TUSER_EN: when defined, the delay latched at tlast SHALL be s_axis_tuser[63:32] of that packet's first beat (captured at the first-beat handshake) if non-zero, else ipd_cycles.
REQ-031 Without INTER_PKT_DELAY_TUSER_EN: the delay SHALL always be ipd_cycles; no tuser capture register is built.

Structure
REQ-032 Shared package inter_pkt_delay_pkg SHALL hold the state enum (IDLE/PASS/GAP) and the tuser delay field offsets (63:32).
REQ-033 One sub-module, ipd_gap_counter (loadable 32-bit down-counter with done flag), is natural; the FSM stays in the top.

Verification
REQ-034 ipd_en=0, 3 back-to-back 4-beat packets, tready=1 -> 12 consecutive beats, no bubbles, pkt_count=3.
REQ-035 ipd_en=1, ipd_cycles=5, two 1-beat packets offered continuously -> second accepted exactly 6 cycles after first.
REQ-036 ipd_cycles=10, change to 2 at GAP cycle 3 -> gap still 10 cycles; next packet gap 2.
REQ-037 GAP of 100 running, ipd_en dropped at cycle 20 -> tready high at cycle 21, held beat transfers.
REQ-038 sw_rst pulse mid-packet (beat 2 of 4) -> state IDLE, pkt_count=0, remaining beats pass, next tlast counts 1.
REQ-039 With INTER_PKT_DELAY_TUSER_EN, tuser[63:32]=7 on first beat, ipd_cycles=3 -> 7-cycle gap; tuser field 0 -> 3-cycle gap.

Source files
------------

// File: rtl/inter_pkt_delay_pkg.sv
// Shared types for inter_pkt_delay: FSM state encoding, gap counter width
// and the position of the per-packet delay field inside tuser.
package inter_pkt_delay_pkg;

  localparam int GAP_CNT_W    = 32;
  localparam int TUSER_DLY_LO = 32;
  localparam int TUSER_DLY_HI = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GAP  = 2'd2
  } ipd_state_t;

endpackage

// File: rtl/inter_pkt_delay_if.sv
// AXI-Stream style packet bus used on both sides of inter_pkt_delay.
interface inter_pkt_delay_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/ipd_gap_counter.sv
// Loadable down-counter timing one inter-packet gap; done flags the final gap cycle.
module ipd_gap_counter
  import inter_pkt_delay_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [GAP_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 done
);

  logic [GAP_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == GAP_CNT_W'(1));

endmodule

// File: rtl/inter_pkt_delay.sv
// Zero-latency stream pass-through that holds off the next packet for a programmable gap.
// Optional macro INTER_PKT_DELAY_TUSER_EN: per-packet delay taken from the first beat's tuser.
//
//   state | meaning
//   IDLE  | between packets, next accepted beat starts a packet
//   PASS  | mid-packet, beats flow straight through
//   GAP   | holding off upstream until the gap counter expires
module inter_pkt_delay
  import inter_pkt_delay_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  inter_pkt_delay_if.slave              s_axis,
  inter_pkt_delay_if.master             m_axis,
  input  logic                          sw_rst,
  input  logic                          ipd_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ipd_cycles,
  output logic [31:0]                   pkt_count
);

  ipd_state_t           state, state_nxt;
  logic                 rst_any;
  logic                 in_gap;
  logic                 s_hs;
  logic                 last_hs;
  logic                 gap_armed;
  logic                 gap_load;
  logic                 gap_done;
  logic [GAP_CNT_W-1:0] dly_sel;

  assign rst_any = axi_reset | sw_rst;
  assign in_gap  = (state == GAP);

  assign m_axis.tdata[C_M_AXIS_DATA_WIDTH-1:0]   = s_axis.tdata[C_S_AXIS_DATA_WIDTH-1:0];
  assign m_axis.tstrb[C_M_AXIS_DATA_WIDTH/8-1:0] = s_axis.tstrb[C_S_AXIS_DATA_WIDTH/8-1:0];
  assign m_axis.tuser[C_M_AXIS_TUSER_WIDTH-1:0]  = s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:0];
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid & ~in_gap;
  assign s_axis.tready = m_axis.tready & ~in_gap;

  assign s_hs    = s_axis.tvalid & s_axis.tready;
  assign last_hs = s_hs & s_axis.tlast;

`ifdef INTER_PKT_DELAY_TUSER_EN
  logic [GAP_CNT_W-1:0] first_dly;
  logic [GAP_CNT_W-1:0] first_dly_q;

  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      first_dly_q <= '0;
    end else if (s_hs && (state == IDLE)) begin
      first_dly_q <= s_axis.tuser[TUSER_DLY_HI:TUSER_DLY_LO];
    end
  end

  // A single-beat packet is its own first beat, so use the live field in IDLE.
  assign first_dly = (state == IDLE) ? s_axis.tuser[TUSER_DLY_HI:TUSER_DLY_LO] : first_dly_q;
  assign dly_sel   = (first_dly != '0) ? first_dly : GAP_CNT_W'(ipd_cycles);
`else
  assign dly_sel = GAP_CNT_W'(ipd_cycles);
`endif

  assign gap_armed = ipd_en & (dly_sel != '0);

  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_hs) begin
          if (!s_axis.tlast) begin
            state_nxt = PASS;
          end else if (gap_armed) begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end
        end
      end
      PASS: begin
        if (last_hs) begin
          if (gap_armed) begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (!ipd_en || gap_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  ipd_gap_counter u_gap_counter (
    .clk      (axi_aclk),
    .rst      (rst_any),
    .load     (gap_load),
    .load_val (dly_sel),
    .dec      (in_gap),
    .done     (gap_done)
  );

  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      pkt_count <= '0;
    end else if (last_hs) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_inter_pkt_delay.sv
// Scoreboard bench for inter_pkt_delay: driver queues expected beats, monitor checks data,
// acceptance cycle against a gap-window model, and the forwarded packet count.
`timescale 1ns/1ps
module tb_inter_pkt_delay;

  localparam int DW = 256;
  localparam int UW = 128;
`ifdef INTER_PKT_DELAY_TUSER_EN
  localparam bit TUSER_EN = 1'b1;
`else
  localparam bit TUSER_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic [UW-1:0]   user;
    logic            last;
    longint          offer;
  } beat_t;

  logic        clk = 1'b0;
  logic        axi_reset;
  logic        sw_rst;
  logic        ipd_en;
  logic [31:0] ipd_cycles;
  logic [31:0] pkt_count;
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  beat_t       exp_q[$];
  longint      gap_end = 0;
  longint      last_tlast = -1;
  bit          in_pkt = 1'b0;
  logic [31:0] first_fld = '0;
  int          exp_pkts = 0;

  inter_pkt_delay_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  inter_pkt_delay_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  inter_pkt_delay dut (
    .axi_aclk   (clk),
    .axi_reset  (axi_reset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .sw_rst     (sw_rst),
    .ipd_en     (ipd_en),
    .ipd_cycles (ipd_cycles),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  // Gap that follows a packet, from the rules: disabled -> none; tuser field wins if enabled and non-zero.
  function automatic longint gap_len(input logic [31:0] fld, input logic en, input logic [31:0] cyc_cfg);
    if (!en) return 0;
    if (TUSER_EN && (fld != 32'd0)) return longint'(fld);
    return longint'(cyc_cfg);
  endfunction

  always @(negedge clk) begin : monitor
    beat_t  e;
    longint want;
    logic   rst_now;
    rst_now = axi_reset | sw_rst;
    if (m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got beat at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 256'(m_if.tdata), 256'(e.data));
        check("beat_ctl", 256'({m_if.tstrb, m_if.tuser, m_if.tlast}), 256'({e.strb, e.user, e.last}));
        want = (!in_pkt && (gap_end > e.offer)) ? gap_end : e.offer;
        check("beat_cycle", 256'(cyc), 256'(want));
      end
      if (!rst_now) begin
        if (!in_pkt) first_fld = m_if.tuser[63:32];
        in_pkt = !m_if.tlast;
        if (m_if.tlast) begin
          exp_pkts++;
          last_tlast = cyc;
          gap_end = cyc + 1 + gap_len(first_fld, ipd_en, ipd_cycles);
        end
      end
    end
    if (rst_now) begin
      exp_pkts = 0;
      in_pkt = 1'b0;
      if (gap_end > cyc + 1) gap_end = cyc + 1;
    end else if (!ipd_en && (cyc > last_tlast) && (cyc < gap_end)) begin
      gap_end = cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds the beat until accepted.
  task automatic send_beat(input logic last, input logic [31:0] fld);
    beat_t b;
    int    waited;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom();
    b.strb = $urandom();
    for (int i = 0; i < UW / 32; i++) b.user[i*32 +: 32] = $urandom();
    b.user[63:32] = fld;
    b.last  = last;
    b.offer = cyc;
    s_if.tdata  = b.data;
    s_if.tstrb  = b.strb;
    s_if.tuser  = b.user;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    exp_q.push_back(b);
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      waited++;
      if (waited >= 600) begin
        n_checks++;
        $display("FAIL accept_timeout: waited %0d cycles from cycle %0d, expected acceptance within 600", waited, b.offer);
        summary();
        $finish;
      end
    end
    tick();
    s_if.tvalid = 1'b0;
  endtask

  task automatic gap_abort(input logic [31:0] len, input int drop_at);
    longint a;
    ipd_en = 1'b1;
    ipd_cycles = len;
    send_beat(1'b1, 32'd0);
    a = last_tlast;
    fork
      send_beat(1'b1, 32'd0);
      begin
        repeat (drop_at - 1) tick();
        check("gap_hold_tready", 256'(s_if.tready), 256'(0));
        ipd_en = 1'b0;
      end
    join
    check("gap_abort_spacing", 256'(last_tlast - a), 256'(drop_at + 1));
  endtask

  initial begin : watchdog
    #600000;
    n_checks++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    summary();
    $finish;
  end

  initial begin : stimulus
    longint a;
    longint b;
    int     len;
    logic [31:0] fld;

    axi_reset = 1'b1;
    sw_rst = 1'b0;
    ipd_en = 1'b0;
    ipd_cycles = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    s_if.tdata = '0;
    s_if.tstrb = '0;
    s_if.tuser = '0;
    m_if.tready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tready", 256'(s_if.tready), 256'(1));
    check("rst_tvalid", 256'(m_if.tvalid), 256'(0));
    check("rst_pkt_count", 256'(pkt_count), 256'(0));
    tick();
    axi_reset = 1'b0;
    tick();

    // back-to-back packets, no gap
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) send_beat(1'(i == 3), $urandom());
    @(negedge clk);
    check("pkt_count_b2b", 256'(pkt_count), 256'(3));
    tick();

    // fixed 5-cycle gap
    ipd_en = 1'b1;
    ipd_cycles = 32'd5;
    send_beat(1'b1, 32'd0);
    a = last_tlast;
    send_beat(1'b1, 32'd0);
    check("gap5_spacing", 256'(last_tlast - a), 256'(6));

    // reprogramming during a running gap
    ipd_cycles = 32'd10;
    send_beat(1'b1, 32'd0);
    a = last_tlast;
    fork
      send_beat(1'b1, 32'd0);
      begin
        tick();
        tick();
        ipd_cycles = 32'd2;
      end
    join
    check("gap10_held", 256'(last_tlast - a), 256'(11));
    b = last_tlast;
    send_beat(1'b1, 32'd0);
    check("gap2_next", 256'(last_tlast - b), 256'(3));

    // enable dropped mid-gap, including the maximum delay
    gap_abort(32'd100, 20);
    gap_abort(32'hFFFF_FFFF, 40);

    // downstream backpressure passes straight up
    m_if.tready = 1'b0;
    @(negedge clk);
    check("tready_follow", 256'(s_if.tready), 256'(0));
    m_if.tready = 1'b1;
    tick();

    // software reset mid-packet
    ipd_en = 1'b0;
    send_beat(1'b0, 32'd0);
    send_beat(1'b0, 32'd0);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    @(negedge clk);
    check("sw_rst_pkt_count", 256'(pkt_count), 256'(0));
    tick();
    send_beat(1'b0, 32'd0);
    send_beat(1'b1, 32'd0);
    @(negedge clk);
    check("post_rst_pkt_count", 256'(pkt_count), 256'(1));
    tick();

    // tuser-supplied delay (ignored in the default build)
    ipd_en = 1'b1;
    ipd_cycles = 32'd3;
    send_beat(1'b1, 32'd7);
    a = last_tlast;
    send_beat(1'b1, 32'd0);
    check("tuser7_spacing", 256'(last_tlast - a), 256'(TUSER_EN ? 8 : 4));
    b = last_tlast;
    send_beat(1'b0, 32'd5);
    send_beat(1'b0, 32'd9);
    send_beat(1'b1, 32'd9);
    check("tuser0_spacing", 256'(last_tlast - b - 2), 256'(4));
    a = last_tlast;
    send_beat(1'b1, 32'd0);
    check("tuser_first_beat", 256'(last_tlast - a), 256'(TUSER_EN ? 6 : 4));

    // randomized traffic and configuration
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 4);
      fld = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 8)) : 32'd0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        if ($urandom_range(0, 4) == 0) ipd_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0) ipd_cycles = 32'($urandom_range(0, 8));
        send_beat(1'(i == len - 1), (i == 0) ? fld : 32'($urandom_range(0, 15)));
      end
    end

    repeat (20) tick();
    @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    check("pkt_count_final", 256'(pkt_count), 256'(exp_pkts));
    summary();
    $finish;
  end

endmodule
